// File: rtl/fifo_wptr_full.sv
`timescale 1ns/1ps
// Write-side pointer and flag logic of an async FIFO: Gray write pointer,
// synchronised read pointer, full / almost-full / fill level, sticky overflow.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  woverflow
);

    localparam logic [ADDR_WIDTH:0] AFULL = AFULL_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wq1_rptr_q, wq1_rptr_d;
    logic [ADDR_WIDTH:0] wq2_rptr_q, wq2_rptr_d;
    logic [ADDR_WIDTH:0] wbin_q, wbin_d;
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] wcount_q, wcount_d;
    logic                wfull_q, wfull_d;
    logic                wafull_q, wafull_d;
    logic                wovf_q, wovf_d;
    logic                wen;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] full_cmp;

    always_comb begin
        wen        = winc & ~wfull_q;
        wq1_rptr_d = rptr;
        wq2_rptr_d = wq1_rptr_q;
        wbin_d     = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
        wptr_d     = (wbin_d >> 1) ^ wbin_d;
        // Gray-to-binary on the synchronised read pointer
        rbin = '0;
        rbin[ADDR_WIDTH] = wq2_rptr_q[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr_q[i];
        end
        full_cmp = {~wq2_rptr_q[ADDR_WIDTH:ADDR_WIDTH-1],
                    wq2_rptr_q[ADDR_WIDTH-2:0]};
        wfull_d  = (wptr_d == full_cmp);
        wcount_d = wbin_d - rbin;
        wafull_d = (wcount_d >= AFULL);
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wq1_rptr_q <= '0;
            wq2_rptr_q <= '0;
            wbin_q     <= '0;
            wptr_q     <= '0;
            wcount_q   <= '0;
            wfull_q    <= 1'b0;
            wafull_q   <= 1'b0;
            wovf_q     <= 1'b0;
        end else begin
            wq1_rptr_q <= wq1_rptr_d;
            wq2_rptr_q <= wq2_rptr_d;
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wcount_q   <= wcount_d;
            wfull_q    <= wfull_d;
            wafull_q   <= wafull_d;
            wovf_q     <= wovf_d;
        end
    end

    assign wclken       = wen;
    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr         = wptr_q;
    assign wcount       = wcount_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
`timescale 1ns/1ps
// Bench for fifo_wptr_full: vector table plus scoreboard-driven sequences.
module tb_fifo_wptr_full;

    typedef struct {
        logic       winc;
        int         rd;
        logic [4:0] cnt;
        logic       full;
        logic       af;
        logic       ovf;
        logic [4:0] ptr;
    } vec_t;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic [4:0] cnt;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] rptr = '0;
    logic       wclken;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wcount;
    logic       woverflow;

    int total = 0;
    int bad   = 0;

    int   m_wr, m_rq1, m_rq2, m_cnt;
    logic m_full, m_af, m_ovf;
    exp_t sb[$];
    vec_t tbl[$];

    fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr),
        .wclken(wclken), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rq1 = 0; m_rq2 = 0; m_cnt = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wptr"}, wptr, 0);
        chk({tag, "_wcount"}, wcount, 0);
        chk({tag, "_wfull"}, wfull, 0);
        chk({tag, "_wafull"}, walmost_full, 0);
        chk({tag, "_wovf"}, woverflow, 0);
    endtask

    // One write-clock cycle: drive, predict, then compare after the edge.
    task automatic step(input logic wi, input int rd);
        exp_t e, g;
        logic [4:0] prev;
        logic acc;
        @(negedge wclk);
        winc = wi;
        rptr = gray(rd % 32);
        #1;
        acc = wi && !m_full;
        chk("wclken", wclken, acc);
        prev = wptr;
        m_wr  = (m_wr + (acc ? 1 : 0)) % 32;
        m_ovf = m_ovf | (wi && m_full);
        m_cnt = (m_wr - m_rq2 + 32) % 32;
        m_full = (m_cnt == 16);
        m_af   = (m_cnt >= 12);
        m_rq2 = m_rq1;
        m_rq1 = rd % 32;
        e.waddr = m_wr[3:0];
        e.wptr  = gray(m_wr);
        e.cnt   = m_cnt[4:0];
        e.full  = m_full;
        e.af    = m_af;
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        g = sb.pop_front();
        chk("waddr", waddr, g.waddr);
        chk("wptr", wptr, g.wptr);
        chk("wcount", wcount, g.cnt);
        chk("wfull", wfull, g.full);
        chk("wafull", walmost_full, g.af);
        chk("wovf", woverflow, g.ovf);
        if (acc) chk("wptr_onebit", $countones(wptr ^ prev), 1);
        else     chk("wptr_hold", wptr, prev);
    endtask

    // Asynchronous reset pulse strictly between clock edges.
    task automatic pulse_reset();
        @(posedge wclk);
        winc = 1'b0;
        #2 wrst = 1'b1;
        #1 chk_zero("async_rst");
        chk("async_rst_wclken", wclken, 0);
        #1 wrst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 1; i <= 16; i++)
            tbl.push_back('{1'b1, 0, 5'(i), i == 16, i >= 12, 1'b0, gray(i)});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b1, 0, 5'd16, 1'b1, 1'b1, 1'b1, 5'b11000});
        tbl.push_back('{1'b0, 1, 5'd16, 1'b1, 1'b1, 1'b1, 5'b11000});
        tbl.push_back('{1'b0, 1, 5'd16, 1'b1, 1'b1, 1'b1, 5'b11000});
        tbl.push_back('{1'b0, 1, 5'd15, 1'b0, 1'b1, 1'b1, 5'b11000});

        model_reset();
        winc = 1'b1;
        repeat (2) @(posedge wclk);
        #1 chk_zero("reset");
        chk("reset_wclken", wclken, 1);
        @(negedge wclk);
        winc = 1'b0;
        wrst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].winc, tbl[i].rd);
            chk($sformatf("tbl%0d_wcount", i), wcount, tbl[i].cnt);
            chk($sformatf("tbl%0d_wfull", i), wfull, tbl[i].full);
            chk($sformatf("tbl%0d_wafull", i), walmost_full, tbl[i].af);
            chk($sformatf("tbl%0d_wovf", i), woverflow, tbl[i].ovf);
            chk($sformatf("tbl%0d_wptr", i), wptr, tbl[i].ptr);
        end

        repeat (3) step(1'b0, 9);
        chk("pre_rst_wcount", wcount, 7);
        chk("pre_rst_wovf", woverflow, 1);
        pulse_reset();
        step(1'b1, 0);
        chk("post_rst_waddr", waddr, 1);

        pulse_reset();
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, (k >= 2) ? k - 2 : 0);
            chk("wrap_wcount", wcount, (k < 4) ? k : 4);
            chk("wrap_wfull", wfull, 0);
            if (k == 16) begin
                chk("wrap_waddr", waddr, 0);
                chk("wrap_wptr16", wptr, 5'b11000);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
